// File: rtl/muldiv_pkg.sv
// Shared constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned CNT_W = 6;
  localparam logic [CNT_W-1:0] ITER_LAST = 6'd31;

  // funct3 encodings of the M extension
  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  // FSM encoding
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_BUSY = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Divide and remainder ops all have funct3[2] set
  function automatic logic op_is_div(input logic [2:0] op);
    return op[2];
  endfunction

  // Ops that interpret rs1 as a signed value
  function automatic logic op_a_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  // Ops that interpret rs2 as a signed value
  function automatic logic op_b_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Combinational result selection and sign correction for the muldiv unit.
module muldiv_sign_fix
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic              valid,
  input  logic [2:0]        op,
  input  logic              neg_a,
  input  logic              neg_b,
  input  logic              div_zero,
  input  logic [2*XLEN-1:0] prod,
  input  logic [XLEN-1:0]   quo,
  input  logic [XLEN-1:0]   rem,
  output logic [XLEN-1:0]   result
);

  localparam int unsigned PROD_W = 2 * XLEN;

  logic              neg_res;
  logic [PROD_W-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;

  // Magnitude results back to two's complement; divide-by-zero bypasses the fixup
  always_comb begin
    neg_res  = neg_a ^ neg_b;
    prod_fix = neg_res ? (~prod + PROD_W'(1)) : prod;
    if (div_zero) begin
      quo_fix = '1;
      rem_fix = rem;
    end else begin
      quo_fix = neg_res ? (~quo + XLEN'(1)) : quo;
      rem_fix = neg_a ? (~rem + XLEN'(1)) : rem;
    end
  end

  // Output word select; zero whenever no result is being presented
  always_comb begin
    result = '0;
    if (valid) begin
      case (op)
        OP_MUL:                        result = prod_fix[XLEN-1:0];
        OP_MULH, OP_MULHSU, OP_MULHU:  result = prod_fix[PROD_W-1:XLEN];
        OP_DIV, OP_DIVU:               result = quo_fix;
        OP_REM, OP_REMU:               result = rem_fix;
        default:                       result = '0;
      endcase
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// Multiply: 32-step shift-add on magnitudes. Divide: 32-step restoring.
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned PROD_W = 2 * XLEN;
  localparam int unsigned REM_W  = XLEN + 1;

  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic              neg_a_q, neg_a_d;
  logic              neg_b_q, neg_b_d;
  logic              divz_q, divz_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  // Multiplicand (multiply) or divisor (divide) magnitude
  logic [XLEN-1:0]   mag_q, mag_d;
  // Multiply: {product hi, multiplier/product lo}. Divide: low half is dividend/quotient
  logic [PROD_W-1:0] acc_q, acc_d;
  // Remainder always ends below the divisor, so 32 bits hold it between steps
  logic [XLEN-1:0]   rem_q, rem_d;

  logic              neg_a_c, neg_b_c;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic              b_zero;
  logic [REM_W-1:0]  mul_sum;
  logic [PROD_W-1:0] mul_next;
  logic [REM_W-1:0]  rem_shift;
  logic [REM_W-1:0]  rem_diff;
  logic              div_ge;

  // Operand sign capture and magnitudes at issue
  always_comb begin
    neg_a_c = op_a_signed(op) & a[XLEN-1];
    neg_b_c = op_b_signed(op) & b[XLEN-1];
    abs_a   = neg_a_c ? (~a + XLEN'(1)) : a;
    abs_b   = neg_b_c ? (~b + XLEN'(1)) : b;
    b_zero  = (b == '0);
  end

  // One shift-add step and one restoring-divide step (33-bit partial remainder)
  always_comb begin
    mul_sum   = {1'b0, acc_q[PROD_W-1:XLEN]} + (acc_q[0] ? {1'b0, mag_q} : REM_W'(0));
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    rem_shift = {rem_q, acc_q[XLEN-1]};
    rem_diff  = rem_shift - {1'b0, mag_q};
    div_ge    = (rem_shift >= {1'b0, mag_q});
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    divz_d  = divz_q;
    cnt_d   = cnt_q;
    mag_d   = mag_q;
    acc_d   = acc_q;
    rem_d   = rem_q;

    case (state_q)
      ST_IDLE: begin
        if (start && !kill) begin
          op_d    = op;
          neg_a_d = neg_a_c;
          neg_b_d = neg_b_c;
          cnt_d   = '0;
          rem_d   = '0;
          divz_d  = op_is_div(op) & b_zero;
          if (op_is_div(op)) begin
            mag_d = abs_b;
            acc_d = {{XLEN{1'b0}}, abs_a};
            if (b_zero) begin
              // Remainder of a divide by zero is the raw dividend
              rem_d   = a;
              state_d = ST_DONE;
            end else begin
              state_d = ST_BUSY;
            end
          end else begin
            mag_d   = abs_a;
            acc_d   = {{XLEN{1'b0}}, abs_b};
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        if (op_is_div(op_q)) begin
          acc_d[XLEN-1:0] = {acc_q[XLEN-2:0], div_ge};
          rem_d           = div_ge ? XLEN'(rem_diff) : XLEN'(rem_shift);
        end else begin
          acc_d = mul_next;
        end
        cnt_d = CNT_W'(cnt_q + CNT_W'(1));
        if (cnt_q == ITER_LAST) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Flush abandons whatever is in flight
    if (kill) begin
      state_d = ST_IDLE;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      divz_q  <= 1'b0;
      cnt_q   <= '0;
      mag_q   <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      divz_q  <= divz_d;
      cnt_q   <= cnt_d;
      mag_q   <= mag_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
    end
  end

  // Stall request rises in the issue cycle so the hazard unit holds EX immediately
  always_comb begin
    busy = ~reset & (((state_q == ST_IDLE) & start & ~kill) | (state_q == ST_BUSY));
    done = (state_q == ST_DONE);
  end

  muldiv_sign_fix #(
    .XLEN(XLEN)
  ) u_sign_fix (
    .valid    (done),
    .op       (op_q),
    .neg_a    (neg_a_q),
    .neg_b    (neg_b_q),
    .div_zero (divz_q),
    .prod     (acc_q),
    .quo      (acc_q[XLEN-1:0]),
    .rem      (rem_q),
    .result   (result)
  );

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed vector bench for ex_muldiv_unit.
module tb_ex_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        kill;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  localparam int NVEC = 24;
  vec_t vecs[NVEC];

  ex_muldiv_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .kill   (kill),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one op and follow it to its done pulse, checking latency and stall length
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp, input string tag);
    int lat;
    int bcnt;
    bit seen;
    int exp_lat;
    exp_lat = (o[2] && (y == 32'd0)) ? 1 : 33;
    @(negedge clk);
    check({tag, " done_before_start"}, {31'd0, done}, 32'd0);
    op = o; a = x; b = y; start = 1'b1;
    #1;
    check({tag, " busy_at_issue"}, {31'd0, busy}, 32'd1);
    bcnt = 1; lat = 0; seen = 1'b0;
    while (!seen && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat == 1) begin
        start = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom);
      end
      #1;
      if (done) begin
        seen = 1'b1;
        check({tag, " result"}, result, exp);
        check({tag, " busy_in_done"}, {31'd0, busy}, 32'd0);
      end else begin
        if (busy) bcnt++;
        if (lat == 16) check({tag, " result_while_busy"}, result, 32'd0);
      end
    end
    check({tag, " done_seen"}, {31'd0, seen}, 32'd1);
    if (seen) begin
      check({tag, " latency"}, 32'(lat), 32'(exp_lat));
      check({tag, " busy_cycles"}, 32'(bcnt), 32'(exp_lat));
    end
  endtask

  initial begin
    vecs[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB}; // MUL 7*-3
    vecs[1]  = '{3'd1, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF}; // MULH 7*-3
    vecs[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE}; // MULHU
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF}; // MULHSU
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD}; // DIV -7/2
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF}; // REM -7%2
    vecs[6]  = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000}; // DIV overflow
    vecs[7]  = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000}; // REM overflow
    vecs[8]  = '{3'd5, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF}; // DIVU /0
    vecs[9]  = '{3'd7, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005}; // REMU /0
    vecs[10] = '{3'd4, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF}; // DIV /0
    vecs[11] = '{3'd6, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB}; // REM -5/0
    vecs[12] = '{3'd5, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E}; // DIVU 100/7
    vecs[13] = '{3'd7, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002}; // REMU 100%7
    vecs[14] = '{3'd3, 32'h8000_0000, 32'h0000_0004, 32'h0000_0002}; // MULHU
    vecs[15] = '{3'd0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000}; // MUL 2^32 low
    vecs[16] = '{3'd3, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001}; // MULHU 2^32 high
    vecs[17] = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000}; // MULH min*min
    vecs[18] = '{3'd2, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF}; // MULHSU -2^31*2
    vecs[19] = '{3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001}; // MUL -1*-1
    vecs[20] = '{3'd4, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'h0000_0002}; // DIV -8/-3
    vecs[21] = '{3'd6, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE}; // REM -8%-3
    vecs[22] = '{3'd5, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF}; // DIVU
    vecs[23] = '{3'd7, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F}; // REMU

    reset = 1'b1; start = 1'b0; kill = 1'b0; op = 3'd0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    #1;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset result", result, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Table vectors, issued back-to-back
    for (int i = 0; i < NVEC; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Kill at iteration 10 of a multiply, then a divide right behind it
    @(negedge clk);
    op = 3'd0; a = 32'd9; b = 32'd9; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    kill = 1'b1;
    #1;
    check("kill busy_before_edge", {31'd0, busy}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    kill = 1'b0;
    #1;
    check("kill busy_after", {31'd0, busy}, 32'd0);
    check("kill done_after", {31'd0, done}, 32'd0);
    run_op(3'd5, 32'd100, 32'd7, 32'd14, "after_kill");

    // Kill together with start in IDLE: nothing issues
    @(negedge clk);
    op = 3'd0; a = 32'd3; b = 32'd3; start = 1'b1; kill = 1'b1;
    #1;
    check("kill_start busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    #1;
    check("kill_start busy_next", {31'd0, busy}, 32'd0);
    check("kill_start done_next", {31'd0, done}, 32'd0);

    // Asynchronous reset mid-BUSY
    @(negedge clk);
    op = 3'd4; a = 32'd1000; b = 32'd3; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst_busy busy", {31'd0, busy}, 32'd0);
    check("rst_busy done", {31'd0, done}, 32'd0);
    check("rst_busy result", result, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (busy || done) begin
        check("rst_busy idle_after_release", {30'd0, busy, done}, 32'd0);
        break;
      end
    end
    check("rst_busy idle_result", result, 32'd0);

    // Asynchronous reset while a divide-by-zero result is presented
    @(negedge clk);
    op = 3'd7; a = 32'h1234_5678; b = 32'd0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("rst_done done_before", {31'd0, done}, 32'd1);
    check("rst_done result_before", result, 32'h1234_5678);
    #2 reset = 1'b1;
    #1;
    check("rst_done done", {31'd0, done}, 32'd0);
    check("rst_done result", result, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run_op(3'd7, 32'd100, 32'd7, 32'd2, "after_reset");

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
